// File: rtl/memory_write_post_buffer.sv
// Posted-write FIFO draining byte writes as one or two aligned dword bus beats.
// Define MEMORY_WRITE_POST_SNOOP_EN to enable the read-hazard snoop compare.
module memory_write_post_buffer #(
    parameter int DEPTH     = 4,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wrbuf_do,
    output logic                 wrbuf_done,
    input  logic [31:0]          wrbuf_address,
    input  logic [2:0]           wrbuf_length,
    input  logic [31:0]          wrbuf_data,
    output logic                 mem_write_do,
    input  logic                 mem_write_done,
    output logic [29:0]          mem_write_address,
    output logic [31:0]          mem_write_data,
    output logic [3:0]           mem_write_byteenable,
    input  logic [31:0]          snoop_address,
    input  logic [2:0]           snoop_length,
    output logic                 snoop_hit,
    output logic                 wrbuf_empty,
    output logic                 wrbuf_full,
    output logic [DEPTH_LOG:0]   wrbuf_count
);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2} state_t;

    logic [31:0] addr_mem [DEPTH];
    logic [2:0]  len_mem  [DEPTH];
    logic [31:0] data_mem [DEPTH];

    state_t               state_q, state_d;
    logic [DEPTH_LOG-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG:0]   count_q, count_d;
    logic                 done_q;
    logic                 do_q, do_d;
    logic [29:0]          maddr_q, maddr_d;
    logic [31:0]          mdata_q, mdata_d;
    logic [3:0]           mbe_q, mbe_d;
    logic                 push, pop;

    logic [31:0] h_addr, h_data;
    logic [2:0]  h_len;
    logic [1:0]  a;
    logic [3:0]  sum;
    logic        two_beats;
    logic [4:0]  sh1, m5;
    logic [5:0]  sh2;
    logic [7:0]  be1_w;
    logic [3:0]  be2;

    assign wrbuf_full = (count_q == (DEPTH_LOG+1)'(DEPTH));
    assign push       = wrbuf_do & ~wrbuf_full & ~done_q;

    assign h_addr    = addr_mem[rd_ptr_q];
    assign h_data    = data_mem[rd_ptr_q];
    assign h_len     = len_mem[rd_ptr_q];
    assign a         = h_addr[1:0];
    assign sum       = {2'b00, a} + {1'b0, h_len};
    assign two_beats = (sum > 4'd4);
    assign sh1       = {a, 3'b000};
    assign sh2       = 6'd32 - {1'b0, sh1};
    assign m5        = (5'd1 << h_len) - 5'd1;
    assign be1_w     = {3'b000, m5} << a;
    assign be2       = (4'd1 << (sum - 4'd4)) - 4'd1;

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr_q] <= wrbuf_address;
            len_mem[wr_ptr_q]  <= wrbuf_length;
            data_mem[wr_ptr_q] <= wrbuf_data;
        end
    end

    always_comb begin
        state_d = state_q;
        do_d    = do_q;
        maddr_d = maddr_q;
        mdata_d = mdata_q;
        mbe_d   = mbe_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    state_d = BEAT1;
                    do_d    = 1'b1;
                    maddr_d = h_addr[31:2];
                    mdata_d = h_data << sh1;
                    mbe_d   = be1_w[3:0];
                end
            end
            BEAT1: begin
                if (mem_write_done) begin
                    if (two_beats) begin
                        state_d = BEAT2;
                        maddr_d = h_addr[31:2] + 30'd1;
                        mdata_d = h_data >> sh2;
                        mbe_d   = be2;
                    end else begin
                        state_d = IDLE;
                        do_d    = 1'b0;
                        pop     = 1'b1;
                    end
                end
            end
            BEAT2: begin
                if (mem_write_done) begin
                    state_d = IDLE;
                    do_d    = 1'b0;
                    pop     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + (DEPTH_LOG+1)'(1);
        else if (pop && !push)
            count_d = count_q - (DEPTH_LOG+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            done_q   <= 1'b0;
            do_q     <= 1'b0;
            maddr_q  <= '0;
            mdata_q  <= '0;
            mbe_q    <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= push;
            do_q    <= do_d;
            maddr_q <= maddr_d;
            mdata_q <= mdata_d;
            mbe_q   <= mbe_d;
            if (push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG'(1);
        end
    end

    assign wrbuf_done           = done_q;
    assign mem_write_do         = do_q;
    assign mem_write_address    = maddr_q;
    assign mem_write_data       = mdata_q;
    assign mem_write_byteenable = mbe_q;
    assign wrbuf_count          = count_q;
    assign wrbuf_empty          = (count_q == '0) && (state_q == IDLE);

`ifdef MEMORY_WRITE_POST_SNOOP_EN
    // Slot i is valid when its distance from the head is below count.
    always_comb begin
        logic [32:0]          s_lo, s_hi;
        logic [32:0]          e_lo, e_hi;
        logic [DEPTH_LOG-1:0] off;
        snoop_hit = 1'b0;
        s_lo = {1'b0, snoop_address};
        s_hi = s_lo + {30'd0, snoop_length};
        for (int i = 0; i < DEPTH; i++) begin
            off  = DEPTH_LOG'(i) - rd_ptr_q;
            e_lo = {1'b0, addr_mem[i]};
            e_hi = e_lo + {30'd0, len_mem[i]};
            if (({1'b0, off} < count_q) && (s_lo < e_hi) && (e_lo < s_hi))
                snoop_hit = 1'b1;
        end
    end
`else
    logic unused_snoop;
    assign unused_snoop = ^{snoop_address, snoop_length};
    assign snoop_hit    = 1'b0;
`endif

    a_len_legal: assert property (
        @(posedge clk) disable iff (rst)
        push |-> (wrbuf_length != 3'd0 && wrbuf_length <= 3'd4)
    );

endmodule

// File: tb/tb_memory_write_post_buffer.sv
// Directed self-checking bench for memory_write_post_buffer.
module tb_memory_write_post_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        wrbuf_do;
    logic        wrbuf_done;
    logic [31:0] wrbuf_address;
    logic [2:0]  wrbuf_length;
    logic [31:0] wrbuf_data;
    logic        mem_write_do;
    logic        mem_write_done;
    logic [29:0] mem_write_address;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_write_byteenable;
    logic [31:0] snoop_address;
    logic [2:0]  snoop_length;
    logic        snoop_hit;
    logic        wrbuf_empty;
    logic        wrbuf_full;
    logic [2:0]  wrbuf_count;

    int tests = 0;
    int fails = 0;

`ifdef MEMORY_WRITE_POST_SNOOP_EN
    localparam logic SN = 1'b1;
`else
    localparam logic SN = 1'b0;
`endif

    memory_write_post_buffer #(.DEPTH(4), .DEPTH_LOG(2)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .wrbuf_do             (wrbuf_do),
        .wrbuf_done           (wrbuf_done),
        .wrbuf_address        (wrbuf_address),
        .wrbuf_length         (wrbuf_length),
        .wrbuf_data           (wrbuf_data),
        .mem_write_do         (mem_write_do),
        .mem_write_done       (mem_write_done),
        .mem_write_address    (mem_write_address),
        .mem_write_data       (mem_write_data),
        .mem_write_byteenable (mem_write_byteenable),
        .snoop_address        (snoop_address),
        .snoop_length         (snoop_length),
        .snoop_hit            (snoop_hit),
        .wrbuf_empty          (wrbuf_empty),
        .wrbuf_full           (wrbuf_full),
        .wrbuf_count          (wrbuf_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] ad, input logic [2:0] ln,
                            input logic [31:0] d, output int cyc);
        wrbuf_address = ad;
        wrbuf_length  = ln;
        wrbuf_data    = d;
        wrbuf_do      = 1'b1;
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!wrbuf_done && cyc < 20);
        wrbuf_do = 1'b0;
        tests++;
        if (wrbuf_done !== 1'b1) begin
            fails++;
            $display("FAIL write_accept addr=%h done=%b want 1", ad, wrbuf_done);
        end
    endtask

    task automatic bus_beat(input logic [29:0] ea, input logic [3:0] eb,
                            input logic [31:0] ed);
        int n = 0;
        while (!mem_write_do && n < 20) begin
            tick();
            n++;
        end
        tests++;
        if (mem_write_do !== 1'b1 || mem_write_address !== ea ||
            mem_write_byteenable !== eb || mem_write_data !== ed) begin
            fails++;
            $display("FAIL beat do=%b addr=%h be=%b data=%h want addr=%h be=%b data=%h",
                     mem_write_do, mem_write_address, mem_write_byteenable,
                     mem_write_data, ea, eb, ed);
        end
        mem_write_done = 1'b1;
        tick();
        mem_write_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tests++;
        if (wrbuf_done !== 1'b0 || mem_write_do !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl done=%b do=%b want 0 0", wrbuf_done, mem_write_do);
        end
        tests++;
        if (wrbuf_empty !== 1'b1 || wrbuf_full !== 1'b0 || wrbuf_count !== 3'd0) begin
            fails++;
            $display("FAIL reset_stat empty=%b full=%b count=%0d want 1 0 0",
                     wrbuf_empty, wrbuf_full, wrbuf_count);
        end
        tests++;
        if (mem_write_address !== 30'd0 || mem_write_byteenable !== 4'd0 ||
            mem_write_data !== 32'd0 || snoop_hit !== 1'b0) begin
            fails++;
            $display("FAIL reset_bus addr=%h be=%b data=%h hit=%b want zeros",
                     mem_write_address, mem_write_byteenable, mem_write_data, snoop_hit);
        end
    endtask

    task automatic test_single();
        int c;
        do_write(32'h1000, 3'd4, 32'hAABBCCDD, c);
        tests++;
        if (c != 1) begin
            fails++;
            $display("FAIL single_latency cycles=%0d want 1", c);
        end
        bus_beat(30'h400, 4'b1111, 32'hAABBCCDD);
        tests++;
        if (wrbuf_empty !== 1'b1 || wrbuf_count !== 3'd0) begin
            fails++;
            $display("FAIL single_empty empty=%b count=%0d want 1 0", wrbuf_empty, wrbuf_count);
        end
    endtask

    task automatic test_unaligned();
        int c;
        do_write(32'h1003, 3'd2, 32'h00001122, c);
        bus_beat(30'h400, 4'b1000, 32'h22000000);
        bus_beat(30'h401, 4'b0001, 32'h00000011);
        tests++;
        if (wrbuf_empty !== 1'b1) begin
            fails++;
            $display("FAIL unaligned_empty empty=%b want 1", wrbuf_empty);
        end
    endtask

    task automatic test_fill();
        int  c;
        int  n;
        logic seen;
        for (int k = 0; k < 4; k++)
            do_write(32'h3000 + 32'(k * 16), 3'd4, 32'hC0DE0000 + 32'(k), c);
        tests++;
        if (wrbuf_count !== 3'd4 || wrbuf_full !== 1'b1) begin
            fails++;
            $display("FAIL fill_full count=%0d full=%b want 4 1", wrbuf_count, wrbuf_full);
        end
        wrbuf_address = 32'h3040;
        wrbuf_length  = 3'd4;
        wrbuf_data    = 32'hC0DE0004;
        wrbuf_do      = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (wrbuf_done) seen = 1'b1;
        end
        tests++;
        if (seen !== 1'b0) begin
            fails++;
            $display("FAIL fill_blocked done_seen=%b want 0", seen);
        end
        bus_beat(30'hC00, 4'b1111, 32'hC0DE0000);
        n = 0;
        while (!wrbuf_done && n < 10) begin
            tick();
            n++;
        end
        wrbuf_do = 1'b0;
        tests++;
        if (wrbuf_done !== 1'b1 || wrbuf_count !== 3'd4) begin
            fails++;
            $display("FAIL fill_fifth done=%b count=%0d want 1 4", wrbuf_done, wrbuf_count);
        end
        for (int k = 1; k < 5; k++)
            bus_beat(30'hC00 + 30'(k * 4), 4'b1111, 32'hC0DE0000 + 32'(k));
    endtask

    task automatic test_push_pop();
        int c;
        do_write(32'h5000, 3'd4, 32'h0000000A, c);
        do_write(32'h5010, 3'd4, 32'h0000000B, c);
        tick();
        tests++;
        if (wrbuf_count !== 3'd2 || mem_write_do !== 1'b1 ||
            mem_write_address !== 30'h1400) begin
            fails++;
            $display("FAIL pp_setup count=%0d do=%b addr=%h want 2 1 1400",
                     wrbuf_count, mem_write_do, mem_write_address);
        end
        wrbuf_address  = 32'h5020;
        wrbuf_length   = 3'd4;
        wrbuf_data     = 32'h0000000C;
        wrbuf_do       = 1'b1;
        mem_write_done = 1'b1;
        tick();
        mem_write_done = 1'b0;
        wrbuf_do       = 1'b0;
        tests++;
        if (wrbuf_done !== 1'b1 || wrbuf_count !== 3'd2) begin
            fails++;
            $display("FAIL pp_same_cycle done=%b count=%0d want 1 2", wrbuf_done, wrbuf_count);
        end
        bus_beat(30'h1404, 4'b1111, 32'h0000000B);
        bus_beat(30'h1408, 4'b1111, 32'h0000000C);
        do_write(32'h5030, 3'd1, 32'h000000D1, c);
        do_write(32'h5035, 3'd2, 32'h0000E1E2, c);
        do_write(32'h5042, 3'd1, 32'h000000F1, c);
        bus_beat(30'h140C, 4'b0001, 32'h000000D1);
        bus_beat(30'h140D, 4'b0110, 32'h00E1E200);
        bus_beat(30'h1410, 4'b0100, 32'h00F10000);
        tests++;
        if (wrbuf_empty !== 1'b1) begin
            fails++;
            $display("FAIL pp_drained empty=%b want 1", wrbuf_empty);
        end
    endtask

    task automatic test_snoop();
        int c;
        do_write(32'h2002, 3'd2, 32'h0000BEEF, c);
        snoop_address = 32'h2000;
        snoop_length  = 3'd2;
        #1;
        tests++;
        if (snoop_hit !== 1'b0) begin
            fails++;
            $display("FAIL snoop_adjacent hit=%b want 0", snoop_hit);
        end
        snoop_address = 32'h2003;
        snoop_length  = 3'd1;
        #1;
        tests++;
        if (snoop_hit !== SN) begin
            fails++;
            $display("FAIL snoop_overlap hit=%b want %b", snoop_hit, SN);
        end
        bus_beat(30'h800, 4'b1100, 32'hBEEF0000);
        tests++;
        if (snoop_hit !== 1'b0) begin
            fails++;
            $display("FAIL snoop_drained hit=%b want 0", snoop_hit);
        end
        do_write(32'h2003, 3'd2, 32'h00001122, c);
        bus_beat(30'h800, 4'b1000, 32'h22000000);
        snoop_address = 32'h2004;
        #1;
        tests++;
        if (snoop_hit !== SN) begin
            fails++;
            $display("FAIL snoop_beat2 hit=%b want %b", snoop_hit, SN);
        end
        bus_beat(30'h801, 4'b0001, 32'h00000011);
        tests++;
        if (snoop_hit !== 1'b0) begin
            fails++;
            $display("FAIL snoop_after hit=%b want 0", snoop_hit);
        end
        snoop_address = 32'h0;
    endtask

    task automatic test_reset_mid();
        int c;
        do_write(32'h1003, 3'd2, 32'h00001122, c);
        do_write(32'h6000, 3'd4, 32'h12345678, c);
        bus_beat(30'h400, 4'b1000, 32'h22000000);
        tests++;
        if (mem_write_do !== 1'b1 || mem_write_address !== 30'h401) begin
            fails++;
            $display("FAIL rmid_beat2 do=%b addr=%h want 1 401", mem_write_do, mem_write_address);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests++;
        if (mem_write_do !== 1'b0 || wrbuf_count !== 3'd0 || wrbuf_empty !== 1'b1) begin
            fails++;
            $display("FAIL rmid_reset do=%b count=%0d empty=%b want 0 0 1",
                     mem_write_do, wrbuf_count, wrbuf_empty);
        end
    endtask

    initial begin
        rst            = 1'b1;
        wrbuf_do       = 1'b0;
        wrbuf_address  = '0;
        wrbuf_length   = 3'd1;
        wrbuf_data     = '0;
        mem_write_done = 1'b0;
        snoop_address  = '0;
        snoop_length   = 3'd1;
        test_reset();
        test_single();
        test_unaligned();
        test_fill();
        test_push_pop();
        test_snoop();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
